// File: rtl/reorder_buffer.sv
// 4-entry circular reorder buffer: allocates on dispatch, captures CDB results,
// retires completed entries in order one per cycle.
module reorder_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AREG_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_dq_valid,
    input  logic [AREG_W-1:0] i_dq_dst_addr,
    output logic              o_dq_ready,
    output logic              o_rat_valid,
    output logic [1:0]        o_rat_rob_addr,
    output logic [AREG_W-1:0] o_rat_dst_addr,
    input  logic              i_cdb_valid,
    input  logic [1:0]        i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_val,
    output logic              o_cmt_valid,
    output logic [1:0]        o_cmt_rob_addr,
    output logic [AREG_W-1:0] o_cmt_dst_addr,
    output logic [DATA_W-1:0] o_cmt_val,
    input  logic              i_flush,
    output logic [2:0]        o_count
);

    logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
    logic [AREG_W-1:0] dst_q [DEPTH];
    logic [AREG_W-1:0] dst_d [DEPTH];
    logic [DATA_W-1:0] val_q [DEPTH];
    logic [DATA_W-1:0] val_d [DEPTH];
    logic [1:0]        head_q, head_d, tail_q, tail_d;
    logic [2:0]        count_q, count_d;

    logic              rat_valid_q, rat_valid_d;
    logic [1:0]        rat_rob_q, rat_rob_d;
    logic [AREG_W-1:0] rat_dst_q, rat_dst_d;
    logic              cmt_valid_q, cmt_valid_d;
    logic [1:0]        cmt_rob_q, cmt_rob_d;
    logic [AREG_W-1:0] cmt_dst_q, cmt_dst_d;
    logic [DATA_W-1:0] cmt_val_q, cmt_val_d;

    logic alloc, commit;

    // Ready looks only at the current count, so a full ROB rejects even while committing.
    assign o_dq_ready = (count_q < 3'(DEPTH));
    assign alloc      = i_dq_valid && o_dq_ready;
    assign commit     = busy_q[head_q] && done_q[head_q];

    always_comb begin
        busy_d      = busy_q;
        done_d      = done_q;
        dst_d       = dst_q;
        val_d       = val_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rat_valid_d = 1'b0;
        rat_rob_d   = rat_rob_q;
        rat_dst_d   = rat_dst_q;
        cmt_valid_d = 1'b0;
        cmt_rob_d   = cmt_rob_q;
        cmt_dst_d   = cmt_dst_q;
        cmt_val_d   = cmt_val_q;

        if (i_flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (i_cdb_valid && busy_q[i_cdb_tag]) begin
                done_d[i_cdb_tag] = 1'b1;
                val_d[i_cdb_tag]  = i_cdb_val;
            end
            if (commit) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + 2'd1;
                cmt_valid_d    = 1'b1;
                cmt_rob_d      = head_q;
                cmt_dst_d      = dst_q[head_q];
                cmt_val_d      = val_q[head_q];
            end
            // Tail entry is never busy here, so allocation cannot collide with commit or CDB.
            if (alloc) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                dst_d[tail_q]  = i_dq_dst_addr;
                val_d[tail_q]  = '0;
                tail_d         = tail_q + 2'd1;
                rat_valid_d    = 1'b1;
                rat_rob_d      = tail_q;
                rat_dst_d      = i_dq_dst_addr;
            end
            case ({alloc, commit})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            busy_q      <= '0;
            done_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dst_q[i] <= '0;
                val_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rat_valid_q <= 1'b0;
            rat_rob_q   <= '0;
            rat_dst_q   <= '0;
            cmt_valid_q <= 1'b0;
            cmt_rob_q   <= '0;
            cmt_dst_q   <= '0;
            cmt_val_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            dst_q       <= dst_d;
            val_q       <= val_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rat_valid_q <= rat_valid_d;
            rat_rob_q   <= rat_rob_d;
            rat_dst_q   <= rat_dst_d;
            cmt_valid_q <= cmt_valid_d;
            cmt_rob_q   <= cmt_rob_d;
            cmt_dst_q   <= cmt_dst_d;
            cmt_val_q   <= cmt_val_d;
        end
    end

    assign o_rat_valid    = rat_valid_q;
    assign o_rat_rob_addr = rat_rob_q;
    assign o_rat_dst_addr = rat_dst_q;
    assign o_cmt_valid    = cmt_valid_q;
    assign o_cmt_rob_addr = cmt_rob_q;
    assign o_cmt_dst_addr = cmt_dst_q;
    assign o_cmt_val      = cmt_val_q;
    assign o_count        = count_q;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 4-entry circular reorder buffer. Sits between the dispatch queue and the register alias table (rat).
- On each accepted dispatch it allocates the tail entry and issues the rename write (ROB index plus architectural destination) to rat.
- Captures results broadcast on the common data bus (CDB).
- Retires completed entries strictly in order, one per cycle, to the architectural register file.

Parameters:
- DEPTH, 4, number of ROB entries. Fixed at 4 because ROB tags are 2 bits.
- DATA_W, 16, result/value width.
- AREG_W, 2, architectural register index width (r0-r3).

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_dq_valid  in  1  dispatch queue presents an instruction
- i_dq_dst_addr  in  2  architectural destination of the dispatched instruction
- o_dq_ready  out  1  ROB can accept a dispatch (count < DEPTH); combinational
- o_rat_valid  out  1  rename write strobe to rat (one-cycle pulse)
- o_rat_rob_addr  out  2  allocated ROB index (tag)
- o_rat_dst_addr  out  2  architectural destination renamed to that tag
- i_cdb_valid  in  1  CDB result valid
- i_cdb_tag  in  2  ROB index producing the result
- i_cdb_val  in  16  result value
- o_cmt_valid  out  1  commit strobe (one-cycle pulse)
- o_cmt_rob_addr  out  2  ROB index being retired
- o_cmt_dst_addr  out  2  architectural destination to update
- o_cmt_val  out  16  committed value
- i_flush  in  1  synchronous flush of all entries
- o_count  out  3  occupied entries, 0-4

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rstn is asynchronous, active-low.
- Reset state: head=0, tail=0, count=0; every entry has busy=0, done=0, dst=0, val=0.
- Output values under reset: all registered outputs are 0; o_dq_ready=1.
- Per-entry state: busy, done, dst[1:0], val[15:0]. Pointers head and tail are 2 bits and wrap 3->0.
- Allocate: when i_dq_valid && o_dq_ready at a clock edge:
  - entry[tail] gets busy=1, done=0, dst=i_dq_dst_addr, val=0;
  - tail increments.
- Rename write: the cycle after an allocate, o_rat_valid=1 with o_rat_rob_addr = the old tail and o_rat_dst_addr = i_dq_dst_addr. Latency is 1 cycle.
- i_dq_valid while full: the dispatch is not accepted, nothing changes, and the dispatch queue must hold its request.
- CDB capture: if i_cdb_valid and entry[i_cdb_tag].busy, that entry gets done=1 and val=i_cdb_val.
  - A CDB write to a non-busy entry is ignored.
  - A repeat CDB write to a done entry overwrites val.
- Commit: if entry[head].busy && entry[head].done at the edge:
  - the next cycle drives o_cmt_valid=1 with o_cmt_rob_addr=head, o_cmt_dst_addr=entry.dst, o_cmt_val=entry.val;
  - entry busy and done are cleared, and head increments.
  - At most one commit per cycle.
- Commit uses registered done only. A CDB write to the head entry in cycle N can commit at edge N+1 at the earliest, with o_cmt_valid visible in N+1..N+2.
- Simultaneous allocate and commit: both take effect and count is unchanged.
  - o_dq_ready is computed from the current count only and ignores a same-cycle commit, so a full ROB rejects dispatch in the cycle it commits.
- CDB tag equal to the current tail during an allocate: the entry is not yet busy, so the CDB write is ignored and the allocate wins.
- count: +1 on allocate, -1 on commit, unchanged when both or neither occur. It never exceeds 4 or goes below 0.
- Flush: i_flush at an edge has priority over everything in that cycle.
  - All busy/done bits clear; head=tail=count=0.
  - o_rat_valid and o_cmt_valid are 0 the next cycle, and same-cycle dispatch, CDB and commit are discarded.
- Strobes: o_rat_valid and o_cmt_valid are single-cycle pulses. Their data fields hold their last values when the strobe is 0.
- Reset mid-operation: asynchronous return to the reset state regardless of pending commit or CDB.

Test Plan:
- Reset then idle: o_count=0, o_dq_ready=1, o_rat_valid=o_cmt_valid=0.
- Dispatch dst=0, 0, 3 on three consecutive cycles -> o_rat pulses in the following cycles: (rob0,r0), (rob1,r0), (rob2,r3); o_count=3.
- Fill all 4 entries, then assert i_dq_valid -> o_dq_ready=0 and no 5th o_rat pulse.
  - Then CDB tag0 val=16'hA5A5 -> o_cmt_valid with (rob0,r0,A5A5) 2 cycles after the CDB.
  - The next dispatch is accepted into rob0 (wrap) and o_count returns to 4.
- Out-of-order completion: entries 0-2 allocated; CDB tag2=0x0002, then tag1=0x0001, then tag0=0x0000 -> commits occur in order rob0, rob1, rob2 on consecutive cycles with matching values.
- CDB to non-busy tag3 with val 0xFFFF -> no state change.
  - Allocating rob3 afterwards shows done=0, and there is no commit until a fresh CDB for tag3.
- i_flush with 3 busy entries plus same-cycle dispatch and CDB -> o_count=0 next cycle, no o_rat or o_cmt pulse, and the next dispatch gets rob0.
